// File: rtl/apb_sram_pkg.sv
// Shared types and constants for the APB-to-SRAM bridge.
// The FSM state encoding and address-check constants live here so the checker and the top agree on them.
package apb_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int MEM_DEPTH = 32;
  localparam int WORD_LSB  = 2;

  // Wait-counter width for a given wait-state count. Never narrower than one bit.
  function automatic int cnt_width(input int ws);
    return (ws < 1) ? 1 : $clog2(ws + 1);
  endfunction

endpackage

// File: rtl/apb_sram_addr_chk.sv
// Combinational APB byte address -> SRAM word index plus error flag.
// Flags misaligned addresses, words beyond MEM_DEPTH and any set bit above the SRAM word index.
module apb_sram_addr_chk
  import apb_sram_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int SRAM_AW   = 10,
  parameter int MEM_DEPTH = apb_sram_pkg::MEM_DEPTH
) (
  input  logic [ADDR_W-1:0]  paddr,
  output logic [SRAM_AW-1:0] word_idx,
  output logic               err
);

  logic misaligned;
  logic beyond_depth;
  logic high_bits;

  assign word_idx     = paddr[SRAM_AW+WORD_LSB-1:WORD_LSB];
  assign misaligned   = |paddr[WORD_LSB-1:0];
  assign beyond_depth = (int'(word_idx) >= MEM_DEPTH);

  // With the default widths there are no address bits above the word index.
  generate
    if (ADDR_W > SRAM_AW + WORD_LSB) begin : g_high
      assign high_bits = |paddr[ADDR_W-1:SRAM_AW+WORD_LSB];
    end else begin : g_no_high
      assign high_bits = 1'b0;
    end
  endgenerate

  assign err = misaligned | beyond_depth | high_bits;

endmodule

// File: rtl/apb_sram_bridge.sv
// APB3 completer that turns each legal transfer into exactly one SRAM strobe.
// Handshake: a transfer is latched on psel & !penable in IDLE; pready (with pslverr) is a registered one-cycle pulse in RESP.
module apb_sram_bridge
  import apb_sram_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int SRAM_AW     = 10,
  parameter int MEM_DEPTH   = apb_sram_pkg::MEM_DEPTH,
  parameter int WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [ADDR_W-1:0]  paddr,
  input  logic [DATA_W-1:0]  pwdata,
  output logic               pready,
  output logic [DATA_W-1:0]  prdata,
  output logic               pslverr,
  output logic               sram_en,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_din,
  input  logic [DATA_W-1:0]  sram_dout
);

  localparam int CNT_W = cnt_width(WAIT_STATES);

  state_t             state;
  logic               wr_q;
  logic               err_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [DATA_W-1:0]  din_q;
  logic [CNT_W-1:0]   cnt;
  logic [SRAM_AW-1:0] word_idx;
  logic               addr_err;

  apb_sram_addr_chk #(
    .ADDR_W   (ADDR_W),
    .SRAM_AW  (SRAM_AW),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_addr_chk (
    .paddr   (paddr),
    .word_idx(word_idx),
    .err     (addr_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      cnt     <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      sram_en <= 1'b0;
      sram_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            wr_q   <= pwrite;
            err_q  <= addr_err;
            addr_q <= word_idx;
            din_q  <= pwdata;
            if (addr_err) begin
              state   <= RESP;
              pready  <= 1'b1;
              pslverr <= 1'b1;
            end else begin
              state   <= ISSUE;
              sram_en <= 1'b1;
              sram_we <= pwrite;
            end
          end
        end
        ISSUE: begin
          // The strobe is one cycle wide whatever happens next.
          sram_en <= 1'b0;
          sram_we <= 1'b0;
          if (!psel) begin
            state <= IDLE;
          end else if (WAIT_STATES == 0) begin
            state   <= RESP;
            pready  <= 1'b1;
            pslverr <= err_q;
          end else begin
            state <= WAIT;
            cnt   <= CNT_W'(WAIT_STATES - 1);
          end
        end
        WAIT: begin
          if (!psel) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state   <= RESP;
            pready  <= 1'b1;
            pslverr <= err_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state   <= IDLE;
          pready  <= 1'b0;
          pslverr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM dout was registered at the end of ISSUE and holds until the next strobe.
  assign prdata    = (state == RESP && !wr_q && !err_q) ? sram_dout : '0;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;

endmodule

// File: tb/tb_apb_sram_bridge.sv
// Bench for apb_sram_bridge: one instance with no wait states and one with three, each behind its own SRAM model.
// Expected results come from a word-array memory model and the transfer latency rules.
module tb_apb_sram_bridge;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- shared APB drive, steered to one DUT ----------------
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  int          cur = 0;
  logic        psel0, psel3;
  assign psel0 = psel && (cur == 0);
  assign psel3 = psel && (cur == 3);

  logic        pready0, pslverr0, sram_en0, sram_we0;
  logic [31:0] prdata0, sram_din0;
  logic [9:0]  sram_addr0;
  logic [31:0] sram_dout0 = '0;
  logic        pready3, pslverr3, sram_en3, sram_we3;
  logic [31:0] prdata3, sram_din3;
  logic [9:0]  sram_addr3;
  logic [31:0] sram_dout3 = '0;

  apb_sram_bridge #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready0), .prdata(prdata0), .pslverr(pslverr0),
    .sram_en(sram_en0), .sram_we(sram_we0), .sram_addr(sram_addr0), .sram_din(sram_din0),
    .sram_dout(sram_dout0)
  );

  apb_sram_bridge #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready3), .prdata(prdata3), .pslverr(pslverr3),
    .sram_en(sram_en3), .sram_we(sram_we3), .sram_addr(sram_addr3), .sram_din(sram_din3),
    .sram_dout(sram_dout3)
  );

  // ---------------- synchronous 32x32 SRAMs ----------------
  logic [31:0] mem0 [32] = '{default: '0};
  logic [31:0] mem3 [32] = '{default: '0};

  always @(posedge clk) begin
    if (sram_en0) begin
      if (sram_we0) mem0[sram_addr0[4:0]] <= sram_din0;
      else          sram_dout0 <= mem0[sram_addr0[4:0]];
    end
    if (sram_en3) begin
      if (sram_we3) mem3[sram_addr3[4:0]] <= sram_din3;
      else          sram_dout3 <= mem3[sram_addr3[4:0]];
    end
  end

  // Monitored view of whichever DUT is currently addressed.
  logic        m_pready, m_pslverr, m_en, m_we;
  logic [31:0] m_prdata, m_din;
  logic [9:0]  m_addr;
  assign m_pready  = (cur == 0) ? pready0    : pready3;
  assign m_pslverr = (cur == 0) ? pslverr0   : pslverr3;
  assign m_prdata  = (cur == 0) ? prdata0    : prdata3;
  assign m_en      = (cur == 0) ? sram_en0   : sram_en3;
  assign m_we      = (cur == 0) ? sram_we0   : sram_we3;
  assign m_addr    = (cur == 0) ? sram_addr0 : sram_addr3;
  assign m_din     = (cur == 0) ? sram_din0  : sram_din3;

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [2][32] = '{default: '0};
  logic [31:0] exp_q [$];

  function automatic bit addr_is_err(input logic [11:0] a);
    return (a % 4 != 0) || ((a / 4) >= 32);
  endfunction

  function automatic int exp_latency(input int dut, input bit err);
    return err ? 1 : (2 + ((dut == 0) ? 0 : 3));
  endfunction

  // ---------------- driver ----------------
  int          obs_lat, obs_en_cnt, obs_en_cycle;
  logic        obs_we, obs_err;
  logic [9:0]  obs_addr;
  logic [31:0] obs_din, obs_prdata;

  task automatic apb_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      psel    = 1'b0;
      penable = 1'b0;
    end
  endtask

  // Runs one transfer; observations are taken on negedges, cycle k counted from the setup cycle.
  task automatic apb_xfer(input int dut, input logic wr, input logic [11:0] a, input logic [31:0] d);
    obs_lat = 0; obs_en_cnt = 0; obs_en_cycle = 0;
    obs_we = 1'b0; obs_err = 1'b0; obs_addr = '0; obs_din = '0; obs_prdata = '0;
    @(negedge clk);
    cur = dut; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      if (k > 1) @(negedge clk);
      if (m_en) begin
        obs_en_cnt++; obs_en_cycle = k; obs_we = m_we; obs_addr = m_addr; obs_din = m_din;
      end
      if (m_pready) begin
        obs_lat = k; obs_prdata = m_prdata; obs_err = m_pslverr;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({pready0, pslverr0, sram_en0, sram_we0} !== 4'b0) begin
      miscompares++; $display("FAIL reset_ctl0 got %b exp 0000", {pready0, pslverr0, sram_en0, sram_we0});
    end
    vectors++;
    if ({pready3, pslverr3, sram_en3, sram_we3} !== 4'b0) begin
      miscompares++; $display("FAIL reset_ctl3 got %b exp 0000", {pready3, pslverr3, sram_en3, sram_we3});
    end
    vectors++;
    if ({prdata0, sram_din0, sram_addr0} !== 74'b0) begin
      miscompares++; $display("FAIL reset_data0 got %h/%h/%h exp 0", prdata0, sram_din0, sram_addr0);
    end
    vectors++;
    if ({prdata3, sram_din3, sram_addr3} !== 74'b0) begin
      miscompares++; $display("FAIL reset_data3 got %h/%h/%h exp 0", prdata3, sram_din3, sram_addr3);
    end
    rst_n = 1'b1;
    apb_idle(2);
  endtask

  task automatic test_ws0_write_read();
    apb_xfer(0, 1'b1, 12'h010, 32'hDEADBEEF);
    ref_mem[0][4] = 32'hDEADBEEF;
    vectors++;
    if (obs_en_cnt !== 1 || obs_en_cycle !== 1 || obs_we !== 1'b1) begin
      miscompares++; $display("FAIL ws0_wr_strobe got cnt=%0d cyc=%0d we=%b exp 1/1/1", obs_en_cnt, obs_en_cycle, obs_we);
    end
    vectors++;
    if (obs_addr !== 10'd4 || obs_din !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL ws0_wr_addr_din got %0d/%h exp 4/deadbeef", obs_addr, obs_din);
    end
    vectors++;
    if (obs_lat !== 2 || obs_err !== 1'b0) begin
      miscompares++; $display("FAIL ws0_wr_resp got lat=%0d err=%b exp 2/0", obs_lat, obs_err);
    end
    apb_xfer(0, 1'b0, 12'h010, 32'h0);
    vectors++;
    if (obs_en_cnt !== 1 || obs_en_cycle !== 1 || obs_we !== 1'b0) begin
      miscompares++; $display("FAIL ws0_rd_strobe got cnt=%0d cyc=%0d we=%b exp 1/1/0", obs_en_cnt, obs_en_cycle, obs_we);
    end
    vectors++;
    if (obs_lat !== 2 || obs_prdata !== ref_mem[0][4]) begin
      miscompares++; $display("FAIL ws0_rd_data got lat=%0d data=%h exp 2/%h", obs_lat, obs_prdata, ref_mem[0][4]);
    end
    apb_idle(1);
  endtask

  task automatic test_errors();
    logic [11:0] bad [4];
    bad = '{12'h080, 12'h006, 12'h801, 12'hFFC};
    for (int i = 0; i < 4; i++) begin
      apb_xfer(i % 2 == 0 ? 0 : 3, i[0], bad[i], $urandom);
      vectors++;
      if (obs_lat !== 1 || obs_err !== 1'b1 || obs_prdata !== 32'h0 || obs_en_cnt !== 0) begin
        miscompares++;
        $display("FAIL err_resp addr=%h got lat=%0d err=%b data=%h en=%0d exp 1/1/0/0", bad[i], obs_lat, obs_err, obs_prdata, obs_en_cnt);
      end
      apb_idle(1);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] d;
    d = $urandom;
    apb_xfer(3, 1'b1, 12'h07C, d);
    ref_mem[1][31] = d;
    vectors++;
    if (obs_lat !== 5 || obs_en_cnt !== 1 || obs_addr !== 10'd31 || obs_din !== d) begin
      miscompares++; $display("FAIL ws3_wr got lat=%0d en=%0d addr=%0d din=%h exp 5/1/31/%h", obs_lat, obs_en_cnt, obs_addr, obs_din, d);
    end
    apb_xfer(3, 1'b0, 12'h07C, 32'h0);
    vectors++;
    if (obs_en_cnt !== 1 || obs_en_cycle !== 1 || obs_we !== 1'b0) begin
      miscompares++; $display("FAIL ws3_rd_strobe got cnt=%0d cyc=%0d we=%b exp 1/1/0", obs_en_cnt, obs_en_cycle, obs_we);
    end
    vectors++;
    if (obs_lat !== 5 || obs_err !== 1'b0 || obs_prdata !== ref_mem[1][31]) begin
      miscompares++; $display("FAIL ws3_rd_data got lat=%0d err=%b data=%h exp 5/0/%h", obs_lat, obs_err, obs_prdata, ref_mem[1][31]);
    end
    apb_idle(1);
  endtask

  task automatic test_back_to_back();
    apb_xfer(0, 1'b1, 12'h000, 32'h1);
    ref_mem[0][0] = 32'h1;
    vectors++;
    if (obs_en_cnt !== 1 || obs_we !== 1'b1 || obs_lat !== 2) begin
      miscompares++; $display("FAIL b2b_wr got en=%0d we=%b lat=%0d exp 1/1/2", obs_en_cnt, obs_we, obs_lat);
    end
    apb_xfer(0, 1'b0, 12'h000, 32'h0);
    vectors++;
    if (obs_en_cnt !== 1 || obs_we !== 1'b0 || obs_lat !== 2 || obs_prdata !== ref_mem[0][0]) begin
      miscompares++; $display("FAIL b2b_rd got en=%0d we=%b lat=%0d data=%h exp 1/0/2/%h", obs_en_cnt, obs_we, obs_lat, obs_prdata, ref_mem[0][0]);
    end
    apb_idle(1);
  endtask

  task automatic test_abort();
    logic [31:0] d;
    bit          saw;
    // psel dropped while waiting: no response may follow.
    @(negedge clk);
    cur = 3; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h07C;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pready3 || sram_en3) saw = 1'b1;
    end
    vectors++;
    if (saw !== 1'b0) begin
      miscompares++; $display("FAIL abort_psel got activity=%b exp 0", saw);
    end
    apb_xfer(3, 1'b0, 12'h07C, 32'h0);
    vectors++;
    if (obs_lat !== 5 || obs_prdata !== ref_mem[1][31]) begin
      miscompares++; $display("FAIL abort_psel_next got lat=%0d data=%h exp 5/%h", obs_lat, obs_prdata, ref_mem[1][31]);
    end
    apb_idle(1);
    // Reset in WAIT: the write strobe in T1 has already reached the SRAM.
    d = $urandom;
    @(negedge clk);
    cur = 3; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h040; pwdata = d;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (sram_en3 !== 1'b0 || pready3 !== 1'b0 || pslverr3 !== 1'b0) begin
      miscompares++; $display("FAIL abort_reset got en=%b rdy=%b err=%b exp 0/0/0", sram_en3, pready3, pslverr3);
    end
    ref_mem[1][16] = d;
    @(negedge clk); rst_n = 1'b1;
    apb_xfer(3, 1'b0, 12'h040, 32'h0);
    vectors++;
    if (obs_lat !== 5 || obs_err !== 1'b0 || obs_prdata !== ref_mem[1][16]) begin
      miscompares++; $display("FAIL abort_reset_next got lat=%0d err=%b data=%h exp 5/0/%h", obs_lat, obs_err, obs_prdata, ref_mem[1][16]);
    end
    apb_idle(1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int          dut, m;
      logic        wr, err;
      logic [11:0] a;
      logic [31:0] d, exp_data;
      dut = ($urandom_range(0, 1) == 0) ? 0 : 3;
      m   = (dut == 0) ? 0 : 1;
      wr  = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) != 0) ? 12'(4 * $urandom_range(0, 31)) : 12'($urandom_range(0, 4095));
      d   = $urandom;
      err = addr_is_err(a);
      exp_q.push_back((!wr && !err) ? ref_mem[m][a / 4] : 32'h0);
      if (wr && !err) ref_mem[m][a / 4] = d;
      apb_xfer(dut, wr, a, d);
      exp_data = exp_q.pop_front();
      vectors++;
      if (obs_lat !== exp_latency(dut, err) || obs_err !== err || obs_en_cnt !== (err ? 0 : 1)) begin
        miscompares++;
        $display("FAIL rand_resp dut=%0d addr=%h got lat=%0d err=%b en=%0d exp %0d/%b/%0d", dut, a, obs_lat, obs_err, obs_en_cnt, exp_latency(dut, err), err, err ? 0 : 1);
      end
      vectors++;
      if (obs_prdata !== exp_data) begin
        miscompares++; $display("FAIL rand_prdata dut=%0d addr=%h got %h exp %h", dut, a, obs_prdata, exp_data);
      end
      if (!err) begin
        vectors++;
        if (obs_we !== wr || obs_addr !== 10'(a / 4) || (wr && obs_din !== d)) begin
          miscompares++; $display("FAIL rand_strobe dut=%0d addr=%h got we=%b idx=%0d din=%h exp %b/%0d/%h", dut, a, obs_we, obs_addr, obs_din, wr, a / 4, d);
        end
      end
      apb_idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_ws0_write_read();
    test_errors();
    test_wait_states();
    test_back_to_back();
    test_abort();
    test_random();
    apb_idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
